// File: rtl/mm_ctrl_pkg.sv
// Shared states, error codes, defaults and output decode for the
// matrix-result run controller.
package mm_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_PE   = 3'd2,
      S_M3   = 3'd3,
      S_M2   = 3'd4,
      S_DISP = 3'd5,
      S_DONE = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_PE   = 2'd1;
   localparam logic [1:0] ERR_M3   = 2'd2;
   localparam logic [1:0] ERR_M2   = 2'd3;

   localparam int TIMEOUT_DEF     = 16;
   localparam int DISP_CYCLES_DEF = 32;

   typedef struct packed {
      logic clear;
      logic run_pe;
      logic run_3x3;
      logic run_2x2;
      logic run_display;
      logic busy;
      logic done;
      logic err;
   } ctrl_out_t;

   localparam ctrl_out_t CTRL_OUT_NONE = 8'h00;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Moore decode: one state maps to exactly one output pattern.
   function automatic ctrl_out_t decode_outputs(input state_t st);
      ctrl_out_t o;
      o = CTRL_OUT_NONE;
      case (st)
         S_IDLE: o = CTRL_OUT_NONE;
         S_CLR:  begin o.clear       = 1'b1; o.busy = 1'b1; end
         S_PE:   begin o.run_pe      = 1'b1; o.busy = 1'b1; end
         S_M3:   begin o.run_3x3     = 1'b1; o.busy = 1'b1; end
         S_M2:   begin o.run_2x2     = 1'b1; o.busy = 1'b1; end
         S_DISP: begin o.run_display = 1'b1; o.busy = 1'b1; end
         S_DONE: o.done = 1'b1;
         S_ERR:  o.err  = 1'b1;
         default: o = CTRL_OUT_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mm_run_controller_phase_timer.sv
// Phase timer: counts while enabled, clears synchronously, and flags when the
// count equals the compare value.
module phase_timer
   import mm_ctrl_pkg::*;
#(
   parameter int TW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic [TW-1:0] cmp,
   output logic [TW-1:0] count,
   output logic          tc
);

   logic [TW-1:0] count_r;

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= {TW{1'b0}};
      end else if (clr) begin
         count_r <= {TW{1'b0}};
      end else if (en) begin
         count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign tc    = (count_r == cmp);

endmodule

// File: rtl/mm_run_controller.sv
// Top-level sequencer: clear, PE array, 3x3 engine, 2x2 engine, display hold,
// with a per-phase timeout and an abort path back to IDLE.
module mm_run_controller
   import mm_ctrl_pkg::*;
#(
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int DISP_CYCLES = DISP_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic       pe_done_i,
   input  logic       mm3_done_i,
   input  logic       mm2_done_i,
   output logic       clear_o,
   output logic       run_pe_o,
   output logic       run_3x3_o,
   output logic       run_2x2_o,
   output logic       run_display_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [1:0] err_code_o,
   output logic [2:0] state_o
);

   localparam int TW = $clog2(max2(TIMEOUT, DISP_CYCLES)) + 1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] DISP_LAST = TW'(DISP_CYCLES - 1);

   state_t        state_r, state_next_s;
   logic [1:0]    err_code_r, err_code_next_s;
   ctrl_out_t     outs_r;
   logic          in_phase_s, tmr_clr_s, tmr_en_s, tmr_tc_s;
   logic [TW-1:0] tmr_cmp_s, tmr_count_s;

   phase_timer #(.TW(TW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr_s),
      .en    (tmr_en_s),
      .cmp   (tmr_cmp_s),
      .count (tmr_count_s),
      .tc    (tmr_tc_s)
   );

   // Timer restarts on every state change and holds at its terminal count.
   assign tmr_clr_s = (state_next_s != state_r);
   assign tmr_en_s  = in_phase_s && (tmr_count_s != tmr_cmp_s);

   // Next-state and err_code selection; abort has priority everywhere.
   always_comb begin
      state_next_s    = state_r;
      err_code_next_s = err_code_r;
      tmr_cmp_s       = TO_LAST;
      in_phase_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (abort_i)      state_next_s = S_IDLE;
            else if (start_i) state_next_s = S_CLR;
            else              state_next_s = S_IDLE;
         end
         S_CLR: begin
            if (abort_i) state_next_s = S_IDLE;
            else         state_next_s = S_PE;
         end
         S_PE: begin
            in_phase_s = 1'b1;
            if (abort_i)        state_next_s = S_IDLE;
            else if (pe_done_i) state_next_s = S_M3;
            else if (tmr_tc_s) begin
               state_next_s    = S_ERR;
               err_code_next_s = ERR_PE;
            end else            state_next_s = S_PE;
         end
         S_M3: begin
            in_phase_s = 1'b1;
            if (abort_i)         state_next_s = S_IDLE;
            else if (mm3_done_i) state_next_s = S_M2;
            else if (tmr_tc_s) begin
               state_next_s    = S_ERR;
               err_code_next_s = ERR_M3;
            end else             state_next_s = S_M3;
         end
         S_M2: begin
            in_phase_s = 1'b1;
            if (abort_i)         state_next_s = S_IDLE;
            else if (mm2_done_i) state_next_s = S_DISP;
            else if (tmr_tc_s) begin
               state_next_s    = S_ERR;
               err_code_next_s = ERR_M2;
            end else             state_next_s = S_M2;
         end
         S_DISP: begin
            in_phase_s = 1'b1;
            tmr_cmp_s  = DISP_LAST;
            if (abort_i)       state_next_s = S_IDLE;
            else if (tmr_tc_s) state_next_s = S_DONE;
            else               state_next_s = S_DISP;
         end
         S_DONE: state_next_s = S_IDLE;
         S_ERR: begin
            if (abort_i) begin
               state_next_s    = S_IDLE;
               err_code_next_s = ERR_NONE;
            end else if (start_i) begin
               state_next_s    = S_CLR;
               err_code_next_s = ERR_NONE;
            end else begin
               state_next_s    = S_ERR;
            end
         end
         default: begin
            state_next_s    = S_IDLE;
            err_code_next_s = ERR_NONE;
         end
      endcase
   end

   // State, err_code and outputs; outputs are the decode of the state being entered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= S_IDLE;
         err_code_r <= ERR_NONE;
         outs_r     <= CTRL_OUT_NONE;
      end else begin
         state_r    <= state_next_s;
         err_code_r <= err_code_next_s;
         outs_r     <= decode_outputs(state_next_s);
      end
   end

   assign clear_o       = outs_r.clear;
   assign run_pe_o      = outs_r.run_pe;
   assign run_3x3_o     = outs_r.run_3x3;
   assign run_2x2_o     = outs_r.run_2x2;
   assign run_display_o = outs_r.run_display;
   assign busy_o        = outs_r.busy;
   assign done_o        = outs_r.done;
   assign err_o         = outs_r.err;
   assign err_code_o    = err_code_r;
   assign state_o       = state_r;

endmodule

// File: tb/tb_mm_run_controller.sv
// Directed self-checking bench for mm_run_controller with default parameters.
module tb_mm_run_controller;

   logic       clk = 1'b0;
   logic       reset, start_i, abort_i, pe_done_i, mm3_done_i, mm2_done_i;
   logic       clear_o, run_pe_o, run_3x3_o, run_2x2_o, run_display_o;
   logic       busy_o, done_o, err_o;
   logic [1:0] err_code_o;
   logic [2:0] state_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int n;
   int dones;

   // outs bit order: clear, run_pe, run_3x3, run_2x2, run_display, busy, done, err
   localparam logic [7:0] O_IDLE = 8'b0000_0000;
   localparam logic [7:0] O_CLR  = 8'b1000_0100;
   localparam logic [7:0] O_PE   = 8'b0100_0100;
   localparam logic [7:0] O_M3   = 8'b0010_0100;
   localparam logic [7:0] O_M2   = 8'b0001_0100;
   localparam logic [7:0] O_DISP = 8'b0000_1100;
   localparam logic [7:0] O_DONE = 8'b0000_0010;
   localparam logic [7:0] O_ERR  = 8'b0000_0001;

   mm_run_controller dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .pe_done_i     (pe_done_i),
      .mm3_done_i    (mm3_done_i),
      .mm2_done_i    (mm2_done_i),
      .clear_o       (clear_o),
      .run_pe_o      (run_pe_o),
      .run_3x3_o     (run_3x3_o),
      .run_2x2_o     (run_2x2_o),
      .run_display_o (run_display_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .err_code_o    (err_code_o),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {clear_o, run_pe_o, run_3x3_o, run_2x2_o, run_display_o, busy_o, done_o, err_o};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_st(input string tag, input logic [2:0] st, input logic [7:0] o);
      check_eq({tag, "_state"}, 32'(state_o), 32'(st));
      check_eq({tag, "_outs"}, 32'(outs()), 32'(o));
   endtask

   // Measures the display hold from its first sampled cycle, then checks DONE and IDLE.
   task automatic check_disp_done(input string tag);
      n = 0;
      dones = 0;
      while (run_display_o && n < 100) begin
         n++;
         dones += int'(done_o);
         tick();
      end
      check_eq({tag, "_disp_len"}, 32'(n), 32'd32);
      check_eq({tag, "_done_in_disp"}, 32'(dones), 32'd0);
      check_st({tag, "_done"}, 3'd6, O_DONE);
      tick();
      check_st({tag, "_idle"}, 3'd0, O_IDLE);
   endtask

   initial begin
      reset = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      pe_done_i = 1'b0; mm3_done_i = 1'b0; mm2_done_i = 1'b0;
      tick(); tick();
      check_st("reset", 3'd0, O_IDLE);
      check_eq("reset_errcode", 32'(err_code_o), 32'd0);
      reset = 1'b1;
      tick();

      // 1. Normal run
      start_i = 1'b1; tick(); start_i = 1'b0;
      check_st("t1_clr", 3'd1, O_CLR);
      tick();
      check_st("t1_pe", 3'd2, O_PE);
      repeat (4) tick();
      pe_done_i = 1'b1; tick(); pe_done_i = 1'b0;
      check_st("t1_m3", 3'd3, O_M3);
      repeat (8) tick();
      mm3_done_i = 1'b1; tick(); mm3_done_i = 1'b0;
      check_st("t1_m2", 3'd4, O_M2);
      repeat (3) tick();
      mm2_done_i = 1'b1; tick(); mm2_done_i = 1'b0;
      check_st("t1_disp", 3'd5, O_DISP);
      check_disp_done("t1");

      // 2. Timeout in M3
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick();
      pe_done_i = 1'b1; tick(); pe_done_i = 1'b0;
      check_st("t2_m3", 3'd3, O_M3);
      n = 0;
      while (state_o == 3'd3 && n < 100) begin
         n++;
         tick();
      end
      check_eq("t2_m3_len", 32'(n), 32'd16);
      check_st("t2_err", 3'd7, O_ERR);
      check_eq("t2_errcode", 32'(err_code_o), 32'd2);
      tick();
      check_st("t2_err_hold", 3'd7, O_ERR);
      start_i = 1'b1; tick(); start_i = 1'b0;
      check_st("t2_restart", 3'd1, O_CLR);
      check_eq("t2_errcode_clr", 32'(err_code_o), 32'd0);

      // 3. pe_done on the last timer cycle
      tick();
      check_st("t3_pe", 3'd2, O_PE);
      repeat (15) tick();
      check_st("t3_pe_last", 3'd2, O_PE);
      pe_done_i = 1'b1; tick(); pe_done_i = 1'b0;
      check_st("t3_m3", 3'd3, O_M3);
      check_eq("t3_errcode", 32'(err_code_o), 32'd0);
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      check_st("t3_abort", 3'd0, O_IDLE);

      // 4. Abort on cycle 10 of DISP, then abort+start in IDLE
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick();
      pe_done_i = 1'b1; tick(); pe_done_i = 1'b0;
      mm3_done_i = 1'b1; tick(); mm3_done_i = 1'b0;
      mm2_done_i = 1'b1; tick(); mm2_done_i = 1'b0;
      check_st("t4_disp", 3'd5, O_DISP);
      repeat (9) tick();
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      check_st("t4_abort", 3'd0, O_IDLE);
      tick();
      check_st("t4_no_done", 3'd0, O_IDLE);
      abort_i = 1'b1; start_i = 1'b1; tick(); abort_i = 1'b0; start_i = 1'b0;
      check_st("t4_abort_start", 3'd0, O_IDLE);

      // 5. Spurious mm2_done in PE and start in M3
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick();
      mm2_done_i = 1'b1; tick(); mm2_done_i = 1'b0;
      check_st("t5_pe_spur", 3'd2, O_PE);
      repeat (2) tick();
      pe_done_i = 1'b1; tick(); pe_done_i = 1'b0;
      check_st("t5_m3", 3'd3, O_M3);
      start_i = 1'b1; tick(); start_i = 1'b0;
      check_st("t5_m3_start", 3'd3, O_M3);
      mm3_done_i = 1'b1; tick(); mm3_done_i = 1'b0;
      check_st("t5_m2", 3'd4, O_M2);
      mm2_done_i = 1'b1; tick(); mm2_done_i = 1'b0;
      check_st("t5_disp", 3'd5, O_DISP);
      check_disp_done("t5");

      // 6. Reset during M2, then a stale mm2_done
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick();
      pe_done_i = 1'b1; tick(); pe_done_i = 1'b0;
      mm3_done_i = 1'b1; tick(); mm3_done_i = 1'b0;
      check_st("t6_m2", 3'd4, O_M2);
      reset = 1'b0; tick(); reset = 1'b1;
      check_st("t6_reset", 3'd0, O_IDLE);
      check_eq("t6_errcode", 32'(err_code_o), 32'd0);
      mm2_done_i = 1'b1; tick(); mm2_done_i = 1'b0;
      check_st("t6_stale", 3'd0, O_IDLE);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
